pa_spsram_init: RTL and testbench

Parametrised single-port synchronous SRAM for LSU-side small buffers. It keeps the CEN/GWEN/WEN active-low port style of the fixed-size SRAM wrappers, and adds:
- a configurable data width split into byte-style write groups;
- a hardware initialisation sequencer that fills the whole array with a constant after reset or on request;
- a registered, holding read port;
- an access-error flag for accesses issued while the sequencer owns the array.

Storage is a behavioural array for FPGA/simulation use. It replaces per-size wrappers where a known post-reset memory content is required.

---
 rtl/pa_spsram_init_if.sv | 28 ++
 rtl/pa_spsram_init.sv | 69 ++++++
 tb/tb_pa_spsram_init.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/pa_spsram_init_if.sv
// User SRAM bus (CEN/GWEN/WEN active-low) plus init-sequencer request/status for pa_spsram_init.
// master = requester side, slave = memory side.
interface pa_spsram_init_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 4,
  parameter int WE_WIDTH   = 4
);
  logic [ADDR_WIDTH-1:0] A;
  logic                  CEN;
  logic                  GWEN;
  logic [WE_WIDTH-1:0]   WEN;
  logic [DATA_WIDTH-1:0] D;
  logic [DATA_WIDTH-1:0] Q;
  logic                  init_req;
  logic                  init_busy;
  logic                  init_done;
  logic                  acc_err;

  modport master (
    output A, CEN, GWEN, WEN, D, init_req,
    input  Q, init_busy, init_done, acc_err
  );

  modport slave (
    input  A, CEN, GWEN, WEN, D, init_req,
    output Q, init_busy, init_done, acc_err
  );
endinterface

// File: rtl/pa_spsram_init.sv
// Single-port SRAM with group write enables and a post-reset/on-request fill sequencer.
// Registered read (1 cycle, Q holds); accesses during the DEPTH-cycle sweep are dropped and flagged.
module pa_spsram_init #(
  parameter int                    ADDR_WIDTH = 6,
  parameter int                    DATA_WIDTH = 4,
  parameter int                    WE_WIDTH   = 4,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input logic              clk,
  input logic              rst_b,
  pa_spsram_init_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int GW    = DATA_WIDTH / WE_WIDTH;

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  busy;
  logic                  user_acc;

  assign busy          = (state == ST_INIT);
  assign user_acc      = ~bus.CEN;
  assign bus.init_busy = busy;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state         <= ST_INIT;
      cnt           <= '0;
      bus.Q         <= '0;
      bus.init_done <= 1'b0;
      bus.acc_err   <= 1'b0;
    end else begin
      bus.init_done <= 1'b0;
      bus.acc_err   <= busy & user_acc;
      if (busy) begin
        // cnt wraps to 0 naturally after the last entry
        cnt <= cnt + 1'b1;
        if (&cnt) begin
          state         <= ST_READY;
          bus.init_done <= 1'b1;
        end
      end else begin
        if (user_acc && bus.GWEN)
          bus.Q <= mem[bus.A];
        if (bus.init_req) begin
          state <= ST_INIT;
          cnt   <= '0;
        end
      end
    end
  end

  // Array has no reset; sweep writes are suppressed while rst_b is held low.
  always_ff @(posedge clk) begin
    if (busy) begin
      if (rst_b)
        mem[cnt] <= INIT_VALUE;
    end else if (user_acc && !bus.GWEN) begin
      for (int i = 0; i < WE_WIDTH; i++) begin
        if (!bus.WEN[i])
          mem[bus.A][i*GW +: GW] <= bus.D[i*GW +: GW];
      end
    end
  end
endmodule

// File: tb/tb_pa_spsram_init.sv
// Self-checking bench for pa_spsram_init: vector table, directed corner sequences, random vs. reference model.
module tb_pa_spsram_init;
  localparam int DEPTH = 64;

  logic clk;
  logic rst_b;

  pa_spsram_init_if #(.ADDR_WIDTH(6), .DATA_WIDTH(4),  .WE_WIDTH(4)) b();
  pa_spsram_init_if #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .WE_WIDTH(4)) b32();

  pa_spsram_init #(.ADDR_WIDTH(6), .DATA_WIDTH(4), .WE_WIDTH(4), .INIT_VALUE(4'h0)) dut (
    .clk(clk), .rst_b(rst_b), .bus(b)
  );
  pa_spsram_init #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .WE_WIDTH(4), .INIT_VALUE(32'hDEADBEEF)) dut32 (
    .clk(clk), .rst_b(rst_b), .bus(b32)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: the array is simply "all INIT_VALUE" once a sweep begins, since the
  // user cannot observe or alter it while busy; busy is a countdown of remaining sweep edges.
  int         busy_left;
  logic [3:0] mq;
  bit         mdone;
  bit         merr;
  logic [3:0] mmem [DEPTH];

  task automatic model_reset();
    busy_left = DEPTH;
    mq        = 4'h0;
    mdone     = 1'b0;
    merr      = 1'b0;
    foreach (mmem[i]) mmem[i] = 4'h0;
  endtask

  task automatic model_edge(input logic cen, input logic gwen, input logic [3:0] wen,
                            input logic [5:0] a, input logic [3:0] d, input logic req);
    if (busy_left > 0) begin
      merr      = !cen;
      mdone     = (busy_left == 1);
      busy_left = busy_left - 1;
    end else begin
      merr  = 1'b0;
      mdone = 1'b0;
      if (!cen) begin
        if (gwen) mq = mmem[a];
        else for (int i = 0; i < 4; i++) if (!wen[i]) mmem[a][i] = d[i];
      end
      if (req) begin
        busy_left = DEPTH;
        foreach (mmem[i]) mmem[i] = 4'h0;
      end
    end
  endtask

  // Drive one cycle of stimulus, take the edge, then compare every output to the model.
  task automatic cyc(input logic cen, input logic gwen, input logic [3:0] wen,
                     input logic [5:0] a, input logic [3:0] d, input logic req);
    b.CEN = cen; b.GWEN = gwen; b.WEN = wen; b.A = a; b.D = d; b.init_req = req;
    @(posedge clk);
    model_edge(cen, gwen, wen, a, d, req);
    #1;
    chk("q",         32'(b.Q),         32'(mq));
    chk("init_busy", 32'(b.init_busy), 32'(busy_left > 0));
    chk("init_done", 32'(b.init_done), 32'(mdone));
    chk("acc_err",   32'(b.acc_err),   32'(merr));
  endtask

  task automatic idle(input logic req);
    cyc(1'b1, 1'b1, 4'hF, 6'd0, 4'h0, req);
  endtask

  // Run until init_done; optionally inject accesses on sweep cycles 3/4 or hold init_req high.
  task automatic sweep(input bit inject, input bit hold, input string nm);
    int k;
    k = 0;
    while (k < 200) begin
      k++;
      if (inject && k == 3)      cyc(1'b0, 1'b1, 4'hF, 6'd2, 4'h0, hold);
      else if (inject && k == 4) cyc(1'b0, 1'b0, 4'h0, 6'd2, 4'hF, hold);
      else                       idle(hold);
      if (inject && (k == 3 || k == 4)) chk("acc_err_pulse", 32'(b.acc_err), 32'd1);
      if (b.init_done) break;
    end
    chk({nm, "_len"}, 32'(k), 32'(DEPTH));
  endtask

  typedef struct {
    logic       cen;
    logic       gwen;
    logic [3:0] wen;
    logic [5:0] a;
    logic [3:0] d;
    logic [3:0] q;
  } vec_t;
  vec_t tbl [10];

  initial begin
    logic [31:0] r;
    logic [31:0] q32_hold;

    tbl[0] = '{1'b0, 1'b0, 4'b0000, 6'd63, 4'h5, 4'h0};
    tbl[1] = '{1'b0, 1'b1, 4'b1111, 6'd63, 4'h0, 4'h5};
    tbl[2] = '{1'b1, 1'b1, 4'b1111, 6'd0,  4'h0, 4'h5};
    tbl[3] = '{1'b0, 1'b0, 4'b1110, 6'd10, 4'hF, 4'h5};
    tbl[4] = '{1'b0, 1'b1, 4'b1111, 6'd10, 4'h0, 4'h1};
    tbl[5] = '{1'b0, 1'b0, 4'b1111, 6'd10, 4'h0, 4'h1};
    tbl[6] = '{1'b0, 1'b1, 4'b1111, 6'd10, 4'h0, 4'h1};
    tbl[7] = '{1'b0, 1'b1, 4'b1111, 6'd0,  4'h0, 4'h0};
    tbl[8] = '{1'b0, 1'b0, 4'b0101, 6'd3,  4'hF, 4'h0};
    tbl[9] = '{1'b0, 1'b1, 4'b1111, 6'd3,  4'h0, 4'hA};

    rst_b = 1'b0;
    b.CEN = 1'b1; b.GWEN = 1'b1; b.WEN = 4'hF; b.A = '0; b.D = '0; b.init_req = 1'b0;
    b32.CEN = 1'b1; b32.GWEN = 1'b1; b32.WEN = 4'hF; b32.A = '0; b32.D = '0; b32.init_req = 1'b0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    chk("rst_q",    32'(b.Q),         32'h0);
    chk("rst_busy", 32'(b.init_busy), 32'h1);
    chk("rst_done", 32'(b.init_done), 32'h0);
    chk("rst_err",  32'(b.acc_err),   32'h0);
    chk("rst_q32",  b32.Q,            32'h0);
    #4 rst_b = 1'b1;

    // Reset sweep with a read and write dropped on sweep cycles 3 and 4
    sweep(1'b1, 1'b0, "reset_sweep");
    for (int i = 0; i < DEPTH; i++) cyc(1'b0, 1'b1, 4'hF, 6'(i), 4'h0, 1'b0);
    cyc(1'b0, 1'b1, 4'hF, 6'd2, 4'h0, 1'b0);
    chk("dropped_write_addr2", 32'(b.Q), 32'h0);

    // Group writes on the 32-bit instance
    b32.CEN = 1'b0; b32.GWEN = 1'b0; b32.WEN = 4'b1010; b32.A = 6'd5; b32.D = 32'h11223344;
    idle(1'b0);
    b32.GWEN = 1'b1; b32.WEN = 4'hF; b32.D = '0;
    idle(1'b0);
    chk("grp_write_q32", b32.Q, 32'hDE22BE44);
    q32_hold = 32'hDE22BE44;
    b32.CEN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle(1'b0);
      chk("grp_hold_q32", b32.Q, q32_hold);
    end

    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].cen, tbl[i].gwen, tbl[i].wen, tbl[i].a, tbl[i].d, 1'b0);
      chk($sformatf("tbl%0d_q", i), 32'(b.Q), 32'(tbl[i].q));
    end

    // Re-init colliding with a write, init_req held through the sweep
    cyc(1'b0, 1'b0, 4'h0, 6'd7, 4'hA, 1'b1);
    chk("reinit_busy", 32'(b.init_busy), 32'h1);
    sweep(1'b0, 1'b1, "reinit_sweep");
    cyc(1'b0, 1'b1, 4'hF, 6'd7, 4'h0, 1'b0);
    chk("collision_addr7", 32'(b.Q), 32'h0);

    // Reset in the middle of a sweep
    cyc(1'b0, 1'b0, 4'h0, 6'd10, 4'h9, 1'b0);
    cyc(1'b0, 1'b1, 4'hF, 6'd10, 4'h0, 1'b0);
    chk("pre_midrst_q", 32'(b.Q), 32'h9);
    idle(1'b1);
    repeat (20) idle(1'b0);
    rst_b = 1'b0;
    #1;
    chk("midrst_q",    32'(b.Q),         32'h0);
    chk("midrst_busy", 32'(b.init_busy), 32'h1);
    chk("midrst_done", 32'(b.init_done), 32'h0);
    model_reset();
    #3 rst_b = 1'b1;
    sweep(1'b0, 1'b0, "midrst_sweep");

    for (int n = 0; n < 400; n++) begin
      logic cen, gwen, req;
      logic [3:0] wen, d;
      logic [5:0] a;
      r    = $urandom;
      cen  = (r[3:0] > 4'd10);
      gwen = r[4];
      wen  = r[8:5];
      a    = r[14:9];
      d    = r[18:15];
      req  = (r[24:19] == 6'd0);
      cyc(cen, gwen, wen, a, d, req);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
